// File: rtl/wb_regfile_if.sv
// Bus bundle between the M->W pipeline register and the write-back register file.
// Carries the W-stage bundle, the D-stage read ports and the exported commit.
interface wb_regfile_if #(
    parameter int RETIRE_W = 32
);
    logic [31:0]         ins_W;
    logic [31:0]         alu_out_W;
    logic [31:0]         D_RD_EXT_W;
    logic [29:0]         pc_4_W;
    logic [4:0]          WD_ADD_W;
    logic [31:0]         HI_W;
    logic [31:0]         LO_W;
    logic [31:0]         RD1_W;
    logic [4:0]          rs_addr_D;
    logic [4:0]          rt_addr_D;
    logic [31:0]         rs_data_D;
    logic [31:0]         rt_data_D;
    logic                wb_we;
    logic [4:0]          wb_addr;
    logic [31:0]         wb_data;
    logic [31:0]         hi_out;
    logic [31:0]         lo_out;
    logic [RETIRE_W-1:0] retire_cnt;

    modport master (
        output ins_W, alu_out_W, D_RD_EXT_W, pc_4_W, WD_ADD_W,
        output HI_W, LO_W, RD1_W, rs_addr_D, rt_addr_D,
        input  rs_data_D, rt_data_D, wb_we, wb_addr, wb_data,
        input  hi_out, lo_out, retire_cnt
    );

    modport slave (
        input  ins_W, alu_out_W, D_RD_EXT_W, pc_4_W, WD_ADD_W,
        input  HI_W, LO_W, RD1_W, rs_addr_D, rt_addr_D,
        output rs_data_D, rt_data_D, wb_we, wb_addr, wb_data,
        output hi_out, lo_out, retire_cnt
    );
endinterface

// File: rtl/wb_regfile.sv
// W-stage commit: decodes the retiring instruction, writes GPR/HI/LO,
// counts retirements and serves D-stage reads with same-cycle bypass.
module wb_regfile #(
    parameter int RETIRE_W = 32,
    parameter int LINK_OFF = 4
) (
    input  logic       clk,
    input  logic       rst,
    wb_regfile_if.slave bus
);
    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_ALU,
        SEL_MEM,
        SEL_LINK,
        SEL_HI,
        SEL_LO
    } sel_e;

    logic [5:0]          op;
    logic [5:0]          fn;
    sel_e                sel;
    logic                ld_hi;
    logic                ld_lo;
    logic                ld_md;
    logic [31:0]         link;
    logic [31:0]         wval;
    logic                we;
    logic [31:0]         gpr_q [32];
    logic [31:0]         hi_q, hi_d;
    logic [31:0]         lo_q, lo_d;
    logic [RETIRE_W-1:0] cnt_q, cnt_d;

    assign op   = bus.ins_W[31:26];
    assign fn   = bus.ins_W[5:0];
    assign link = {bus.pc_4_W, 2'b00} + 32'(LINK_OFF);

    always_comb begin
        sel   = SEL_NONE;
        ld_hi = 1'b0;
        ld_lo = 1'b0;
        ld_md = 1'b0;
        if (bus.ins_W != '0) begin
            case (op) inside
                6'h00: begin
                    case (fn) inside
                        6'h08:         sel = SEL_NONE;
                        6'h09:         sel = SEL_LINK;
                        6'h10:         sel = SEL_HI;
                        6'h11:         ld_hi = 1'b1;
                        6'h12:         sel = SEL_LO;
                        6'h13:         ld_lo = 1'b1;
                        [6'h18:6'h1B]: ld_md = 1'b1;
                        default:       sel = SEL_ALU;
                    endcase
                end
                6'h03:                             sel = SEL_LINK;
                6'h20, 6'h21, 6'h23, 6'h24, 6'h25: sel = SEL_MEM;
                [6'h08:6'h0F]:                     sel = SEL_ALU;
                default:                           sel = SEL_NONE;
            endcase
        end
    end

    always_comb begin
        wval = '0;
        unique case (sel)
            SEL_ALU:  wval = bus.alu_out_W;
            SEL_MEM:  wval = bus.D_RD_EXT_W;
            SEL_LINK: wval = link;
            SEL_HI:   wval = hi_q;
            SEL_LO:   wval = lo_q;
            default:  wval = '0;
        endcase
    end

    assign we          = (sel != SEL_NONE) && (bus.WD_ADD_W != 5'd0);
    assign bus.wb_we   = we;
    assign bus.wb_addr = bus.WD_ADD_W;
    assign bus.wb_data = we ? wval : 32'd0;

    // Bypass lets D read a value in the same cycle W commits it.
    always_comb begin
        bus.rs_data_D = gpr_q[bus.rs_addr_D];
        if (bus.rs_addr_D == 5'd0)
            bus.rs_data_D = '0;
        else if (we && bus.rs_addr_D == bus.WD_ADD_W)
            bus.rs_data_D = wval;
    end

    always_comb begin
        bus.rt_data_D = gpr_q[bus.rt_addr_D];
        if (bus.rt_addr_D == 5'd0)
            bus.rt_data_D = '0;
        else if (we && bus.rt_addr_D == bus.WD_ADD_W)
            bus.rt_data_D = wval;
    end

    always_comb begin
        hi_d  = hi_q;
        lo_d  = lo_q;
        cnt_d = cnt_q;
        if (ld_hi)
            hi_d = bus.RD1_W;
        if (ld_lo)
            lo_d = bus.RD1_W;
        if (ld_md) begin
            hi_d = bus.HI_W;
            lo_d = bus.LO_W;
        end
        if (bus.ins_W != '0)
            cnt_d = cnt_q + RETIRE_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++)
                gpr_q[i] <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (we)
                gpr_q[bus.WD_ADD_W] <= wval;
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            cnt_q <= cnt_d;
        end
    end

    assign bus.hi_out     = hi_q;
    assign bus.lo_out     = lo_q;
    assign bus.retire_cnt = cnt_q;
endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: stimulus queues expectations,
// a monitor samples the outputs and retires them.
module tb_wb_regfile;
    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    wb_regfile_if #(.RETIRE_W(32)) bus ();
    wb_regfile_if #(.RETIRE_W(2))  bus2 ();

    wb_regfile #(.RETIRE_W(32), .LINK_OFF(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Narrow-counter copy shares all inputs so the wrap is reachable.
    wb_regfile #(.RETIRE_W(2), .LINK_OFF(4)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2.slave)
    );

    assign bus2.ins_W      = bus.ins_W;
    assign bus2.alu_out_W  = bus.alu_out_W;
    assign bus2.D_RD_EXT_W = bus.D_RD_EXT_W;
    assign bus2.pc_4_W     = bus.pc_4_W;
    assign bus2.WD_ADD_W   = bus.WD_ADD_W;
    assign bus2.HI_W       = bus.HI_W;
    assign bus2.LO_W       = bus.LO_W;
    assign bus2.RD1_W      = bus.RD1_W;
    assign bus2.rs_addr_D  = bus.rs_addr_D;
    assign bus2.rt_addr_D  = bus.rt_addr_D;

    localparam int K_RS  = 0;
    localparam int K_RT  = 1;
    localparam int K_WE  = 2;
    localparam int K_WD  = 3;
    localparam int K_HI  = 4;
    localparam int K_LO  = 5;
    localparam int K_CNT = 6;
    localparam int K_C2  = 7;
    localparam int K_WA  = 8;

    typedef struct {
        string       name;
        int          kind;
        logic [31:0] exp;
    } chk_t;

    chk_t sbq[$];
    event smp;
    int   checks = 0;
    int   failures = 0;

    function automatic logic [31:0] pick(input int k);
        case (k)
            K_RS:    return bus.rs_data_D;
            K_RT:    return bus.rt_data_D;
            K_WE:    return {31'd0, bus.wb_we};
            K_WD:    return bus.wb_data;
            K_HI:    return bus.hi_out;
            K_LO:    return bus.lo_out;
            K_CNT:   return bus.retire_cnt;
            K_C2:    return {30'd0, bus2.retire_cnt};
            K_WA:    return {27'd0, bus.wb_addr};
            default: return 32'hXXXX_XXXX;
        endcase
    endfunction

    task automatic expect_v(input string n, input int k, input logic [31:0] e);
        sbq.push_back('{n, k, e});
    endtask

    task automatic probe();
        -> smp;
        #2;
    endtask

    initial begin
        forever begin
            chk_t        c;
            logic [31:0] act;
            @(smp);
            #1;
            while (sbq.size() > 0) begin
                c   = sbq.pop_front();
                act = pick(c.kind);
                checks++;
                if (act !== c.exp) begin
                    failures++;
                    $display("FAIL %s actual=%h required=%h", c.name, act, c.exp);
                end
            end
        end
    end

    function automatic logic [31:0] rins(input logic [5:0] fn);
        return {6'h00, 5'd1, 5'd2, 5'd0, 5'd0, fn};
    endfunction

    function automatic logic [31:0] iins(input logic [5:0] op);
        return {op, 26'h0012345};
    endfunction

    task automatic cyc(
        input logic [31:0] ins,
        input logic [4:0]  wd,
        input logic [31:0] alu,
        input logic [31:0] mem,
        input logic [29:0] pc4,
        input logic [31:0] hw,
        input logic [31:0] lw,
        input logic [31:0] rd1,
        input logic [4:0]  rs,
        input logic [4:0]  rt
    );
        @(negedge clk);
        bus.ins_W      = ins;
        bus.WD_ADD_W   = wd;
        bus.alu_out_W  = alu;
        bus.D_RD_EXT_W = mem;
        bus.pc_4_W     = pc4;
        bus.HI_W       = hw;
        bus.LO_W       = lw;
        bus.RD1_W      = rd1;
        bus.rs_addr_D  = rs;
        bus.rt_addr_D  = rt;
    endtask

    task automatic bubble(input logic [4:0] rs, input logic [4:0] rt);
        cyc(32'd0, 5'd7, 32'h0BAD_0BAD, 32'h0BAD_0BAD, 30'd0,
            32'hEEEE, 32'hFFFF, 32'h9999, rs, rt);
    endtask

    initial begin
        bus.ins_W = '0; bus.WD_ADD_W = '0; bus.alu_out_W = '0;
        bus.D_RD_EXT_W = '0; bus.pc_4_W = '0; bus.HI_W = '0;
        bus.LO_W = '0; bus.RD1_W = '0; bus.rs_addr_D = '0; bus.rt_addr_D = '0;

        bubble(5'd5, 5'd0);
        expect_v("rst_hi", K_HI, 32'd0);
        expect_v("rst_lo", K_LO, 32'd0);
        expect_v("rst_cnt", K_CNT, 32'd0);
        expect_v("rst_rs5", K_RS, 32'd0);
        probe();
        rst = 1'b1;

        cyc(rins(6'h21), 5'd5, 32'h1234, 32'h0, 30'd0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0);
        expect_v("w5_wa", K_WA, 32'd5);
        probe();
        cyc(rins(6'h18), 5'd0, 32'h0, 32'h0, 30'd0, 32'hAA, 32'hBB, 32'h0, 5'd0, 5'd0);
        probe();
        bubble(5'd5, 5'd0);
        expect_v("pre_rs5", K_RS, 32'h1234);
        expect_v("pre_hi", K_HI, 32'hAA);
        expect_v("pre_lo", K_LO, 32'hBB);
        expect_v("pre_cnt", K_CNT, 32'd2);
        probe();
        rst = 1'b0;
        expect_v("arst_rs5", K_RS, 32'd0);
        expect_v("arst_hi", K_HI, 32'd0);
        expect_v("arst_lo", K_LO, 32'd0);
        expect_v("arst_cnt", K_CNT, 32'd0);
        probe();
        cyc(rins(6'h21), 5'd6, 32'h77, 32'h0, 30'd0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0);
        probe();
        bubble(5'd6, 5'd5);
        rst = 1'b1;
        expect_v("drop_rs6", K_RS, 32'd0);
        expect_v("drop_rt5", K_RT, 32'd0);
        expect_v("drop_cnt", K_CNT, 32'd0);
        probe();

        cyc(rins(6'h21), 5'd8, 32'hDEADBEEF, 32'h0, 30'd0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0);
        expect_v("addu_we", K_WE, 32'd1);
        expect_v("addu_wd", K_WD, 32'hDEADBEEF);
        probe();
        cyc(iins(6'h23), 5'd9, 32'h1111, 32'h55AA, 30'd0, 32'h0, 32'h0, 32'h0, 5'd9, 5'd8);
        expect_v("lw_wd", K_WD, 32'h55AA);
        expect_v("lw_byp_rs9", K_RS, 32'h55AA);
        expect_v("rd_rt8", K_RT, 32'hDEADBEEF);
        probe();
        cyc(iins(6'h03), 5'd31, 32'h0, 32'h0, 30'h0010_0001, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0);
        expect_v("jal_wd", K_WD, 32'h0040_0008);
        probe();
        bubble(5'd0, 5'd0);
        expect_v("cnt3", K_CNT, 32'd3);
        expect_v("c2_max", K_C2, 32'd3);
        probe();
        bubble(5'd0, 5'd0);
        probe();
        cyc(iins(6'h2B), 5'd4, 32'h44, 32'h0, 30'd0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0);
        expect_v("sw_we", K_WE, 32'd0);
        probe();
        cyc(iins(6'h04), 5'd4, 32'h44, 32'h0, 30'd0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0);
        expect_v("beq_we", K_WE, 32'd0);
        expect_v("c2_wrap", K_C2, 32'd0);
        probe();
        bubble(5'd31, 5'd9);
        expect_v("cnt5", K_CNT, 32'd5);
        expect_v("rd_r31", K_RS, 32'h0040_0008);
        expect_v("rd_r9", K_RT, 32'h55AA);
        expect_v("no_wr4", K_WE, 32'd0);
        probe();

        cyc(rins(6'h21), 5'd0, 32'hFFFF, 32'h0, 30'd0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0);
        expect_v("r0_we", K_WE, 32'd0);
        expect_v("r0_wd", K_WD, 32'd0);
        expect_v("r0_rs", K_RS, 32'd0);
        probe();
        bubble(5'd4, 5'd0);
        expect_v("r0_after", K_RT, 32'd0);
        expect_v("r4_clean", K_RS, 32'd0);
        probe();

        cyc(rins(6'h18), 5'd0, 32'h0, 32'h0, 30'd0, 32'd1, 32'd2, 32'h0, 5'd0, 5'd0);
        expect_v("mult_we", K_WE, 32'd0);
        expect_v("mult_prehi", K_HI, 32'd0);
        probe();
        cyc(rins(6'h12), 5'd3, 32'h0, 32'h0, 30'd0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0);
        expect_v("mult_hi", K_HI, 32'd1);
        expect_v("mult_lo", K_LO, 32'd2);
        expect_v("mflo_wd", K_WD, 32'd2);
        probe();
        cyc(rins(6'h11), 5'd5, 32'h0, 32'h0, 30'd0, 32'h0, 32'h0, 32'd7, 5'd3, 5'd0);
        expect_v("mthi_we", K_WE, 32'd0);
        expect_v("rd_r3", K_RS, 32'd2);
        probe();
        bubble(5'd0, 5'd0);
        expect_v("mthi_hi", K_HI, 32'd7);
        expect_v("mthi_lo", K_LO, 32'd2);
        probe();

        cyc(rins(6'h21), 5'd4, 32'hA5, 32'h0, 30'd0, 32'h0, 32'h0, 32'h0, 5'd4, 5'd4);
        expect_v("byp_rs4", K_RS, 32'hA5);
        expect_v("byp_rt4", K_RT, 32'hA5);
        probe();
        bubble(5'd4, 5'd8);
        expect_v("rd_r4", K_RS, 32'hA5);
        expect_v("rd_r8", K_RT, 32'hDEADBEEF);
        expect_v("cnt_end", K_CNT, 32'd10);
        probe();

        #20;
        checks++;
        if (sbq.size() != 0) begin
            failures++;
            $display("FAIL sbq_drain actual=%0d required=0", sbq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
